// File: rtl/data_mem_arbiter_if.sv
// GPU-side data memory channels: per-channel read and write valid/ready handshakes.
// The GPU memory controller is the master; the SRAM arbiter is the slave.
interface data_mem_arbiter_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0] mem_read_valid;
  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_read_ready;
  logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_valid;
  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter serving all GPU read/write channels from one single-port SRAM.
// 3 cycles from sampled valid to ready, one access per 3 cycles; ready pulses cannot be back-pressured.
module data_mem_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_arbiter_if.slave    gpu,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata,
  output logic                 busy
);
  localparam int NUM_SLOTS = 2 * NUM_CHANNELS;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       rr_q, rr_d;
  logic [SLOT_W-1:0]       win_q, win_d;
  logic [SLOT_W-1:0]       grant_idx;
  logic                    grant_any;
  logic [NUM_SLOTS-1:0]    hold_q, hold_d, hold_set;
  logic [NUM_SLOTS-1:0]    slot_vld, eligible;
  logic                    sram_en_q, sram_en_d;
  logic                    sram_we_q, sram_we_d;
  logic [ADDR_BITS-1:0]    sram_addr_q, sram_addr_d;
  logic [DATA_BITS-1:0]    sram_wdata_q, sram_wdata_d;
  logic [NUM_CHANNELS-1:0] rd_rdy_q, rd_rdy_d;
  logic [NUM_CHANNELS-1:0] wr_rdy_q, wr_rdy_d;
  logic [DATA_BITS-1:0]    rd_data_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rd_data_d [NUM_CHANNELS];

  // Even slots are reads, odd slots are writes of channel slot/2.
  always_comb begin
    slot_vld = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      slot_vld[2*c]   = gpu.mem_read_valid[c];
      slot_vld[2*c+1] = gpu.mem_write_valid[c];
    end
  end

  assign eligible = slot_vld & ~hold_q;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = SLOT_W'(idx);
      end
    end
  end

  always_comb begin
    int gch;
    int wch;
    state_d      = state_q;
    rr_d         = rr_q;
    win_d        = win_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    rd_rdy_d     = '0;
    wr_rdy_d     = '0;
    rd_data_d    = rd_data_q;
    hold_set     = '0;
    gch          = int'(grant_idx) / 2;
    wch          = int'(win_q) / 2;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          win_d     = grant_idx;
          rr_d      = (int'(grant_idx) == NUM_SLOTS - 1) ? '0 : grant_idx + 1'b1;
          sram_en_d = 1'b1;
          sram_we_d = grant_idx[0];
          if (grant_idx[0]) begin
            sram_addr_d  = gpu.mem_write_address[gch];
            sram_wdata_d = gpu.mem_write_data[gch];
          end else begin
            sram_addr_d  = gpu.mem_read_address[gch];
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        sram_en_d = 1'b0;
        sram_we_d = 1'b0;
        state_d   = RESPOND;
      end
      RESPOND: begin
        if (win_q[0]) begin
          wr_rdy_d[wch] = 1'b1;
        end else begin
          rd_rdy_d[wch]  = 1'b1;
          rd_data_d[wch] = sram_rdata;
        end
        hold_set[win_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A hold bit lives from the ready pulse until the requester is seen to drop valid.
  assign hold_d = (hold_q | hold_set) & slot_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      win_q        <= '0;
      hold_q       <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      rd_rdy_q     <= '0;
      wr_rdy_q     <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) rd_data_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      win_q        <= win_d;
      hold_q       <= hold_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rd_rdy_q     <= rd_rdy_d;
      wr_rdy_q     <= wr_rdy_d;
      for (int c = 0; c < NUM_CHANNELS; c++) rd_data_q[c] <= rd_data_d[c];
    end
  end

  assign sram_en             = sram_en_q;
  assign sram_we             = sram_we_q;
  assign sram_addr           = sram_addr_q;
  assign sram_wdata          = sram_wdata_q;
  assign busy                = (state_q != IDLE);
  assign gpu.mem_read_ready  = rd_rdy_q;
  assign gpu.mem_write_ready = wr_rdy_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_rd_data
    assign gpu.mem_read_data[c] = rd_data_q[c];
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a scoreboard queue of expected ready responses is
// checked by an independent monitor, while the stimulus thread checks SRAM pins and latency.
module tb_data_mem_arbiter;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) gpu_if ();

  logic          sram_en, sram_we, busy;
  logic [AB-1:0] sram_addr;
  logic [DB-1:0] sram_wdata, sram_rdata;

  data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) dut (
    .clk        (clk),
    .reset      (reset),
    .gpu        (gpu_if),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  // Single-port synchronous SRAM model.
  logic [DB-1:0] mem [256];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct packed {
    logic       wr;
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_rsp(input int ch, input bit wr, input logic [7:0] d);
    exp_t e;
    e.wr   = wr;
    e.ch   = 2'(ch);
    e.data = wr ? 8'h00 : d;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int ch, input logic wr, input logic [7:0] d);
    exp_t got;
    exp_t e;
    got.wr   = wr;
    got.ch   = 2'(ch);
    got.data = d;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: got {wr,ch,data}=0x%0h, expected no response", got);
    end else begin
      e = sb.pop_front();
      check("sb_response {wr,ch,data}", 32'(got), 32'(e));
    end
  endtask

  // Monitor: every ready pulse must match the next queued response.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (gpu_if.mem_read_ready[c] === 1'b1)  pop_cmp(c, 1'b0, gpu_if.mem_read_data[c]);
      if (gpu_if.mem_write_ready[c] === 1'b1) pop_cmp(c, 1'b1, 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string name);
    check({name, "_busy"},  32'(busy), 32'd0);
    check({name, "_en_we"}, 32'({sram_en, sram_we}), 32'd0);
    check({name, "_addr"},  32'(sram_addr), 32'd0);
    check({name, "_wdata"}, 32'(sram_wdata), 32'd0);
    check({name, "_ready"}, 32'({gpu_if.mem_read_ready, gpu_if.mem_write_ready}), 32'd0);
    check({name, "_rdata"}, {gpu_if.mem_read_data[0], gpu_if.mem_read_data[1],
                             gpu_if.mem_read_data[2], gpu_if.mem_read_data[3]}, 32'd0);
  endtask

  task automatic reset_and_check(input string name);
    reset = 1'b1;
    tick();
    tick();
    check_rst(name);
    reset = 1'b0;
  endtask

  // One isolated access, GPU-style: valid held until one cycle after ready.
  task automatic do_access(input string name, input int ch, input bit wr,
                           input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] exp_rd);
    int         lat;
    int         en_cnt;
    bit         seen;
    logic       we_s;
    logic [7:0] addr_s, wd_s;
    expect_rsp(ch, wr, exp_rd);
    if (wr) begin
      gpu_if.mem_write_valid[ch]   = 1'b1;
      gpu_if.mem_write_address[ch] = addr;
      gpu_if.mem_write_data[ch]    = wdata;
    end else begin
      gpu_if.mem_read_valid[ch]    = 1'b1;
      gpu_if.mem_read_address[ch]  = addr;
    end
    lat = 0; en_cnt = 0; seen = 1'b0; we_s = 1'b0; addr_s = '0; wd_s = '0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (sram_en) begin
        en_cnt++;
        we_s   = sram_we;
        addr_s = sram_addr;
        wd_s   = sram_wdata;
      end
      seen = wr ? gpu_if.mem_write_ready[ch] : gpu_if.mem_read_ready[ch];
    end
    check({name, "_latency"},   32'(lat), 32'd3);
    check({name, "_en_cycles"}, 32'(en_cnt), 32'd1);
    check({name, "_we"},        32'(we_s), 32'(wr));
    check({name, "_addr"},      32'(addr_s), 32'(addr));
    if (wr) check({name, "_wdata"}, 32'(wd_s), 32'(wdata));
    tick();
    gpu_if.mem_read_valid[ch]  = 1'b0;
    gpu_if.mem_write_valid[ch] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         served[NC];
    bit         drop_n[NC];
    bit         raise_n[NC];
    int         got, cyc, lat, n_rdy, busy_cnt, rd_at, wr_at;
    bit         drop_rd, drop_wr;

    reset = 1'b1;
    gpu_if.mem_read_valid  = '0;
    gpu_if.mem_write_valid = '0;
    for (int c = 0; c < NC; c++) begin
      gpu_if.mem_read_address[c]  = '0;
      gpu_if.mem_write_address[c] = '0;
      gpu_if.mem_write_data[c]    = '0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h99;
    mem[8'h05] = 8'h11;
    for (int c = 0; c < NC; c++) mem[8'h40 + c] = 8'(8'h50 + c);

    reset_and_check("rst_init");

    do_access("rd_ch2",   2, 1'b0, 8'h10, 8'h00, 8'hA5);
    do_access("wr_ch1",   1, 1'b1, 8'h20, 8'h3C, 8'h00);
    do_access("rd_back",  0, 1'b0, 8'h20, 8'h00, 8'h3C);

    // Round-robin: four readers, each re-requesting after its ready, two rounds from rr=0.
    reset_and_check("rst_rr");
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) expect_rsp(c, 1'b0, 8'(8'h50 + c));
    for (int c = 0; c < NC; c++) begin
      gpu_if.mem_read_address[c] = 8'(8'h40 + c);
      gpu_if.mem_read_valid[c]   = 1'b1;
      served[c] = 0; drop_n[c] = 1'b0; raise_n[c] = 1'b0;
    end
    got = 0; cyc = 0;
    while (got < 8 && cyc < 80) begin
      tick();
      cyc++;
      for (int c = 0; c < NC; c++) begin
        if (drop_n[c]) begin
          gpu_if.mem_read_valid[c] = 1'b0;
          drop_n[c]  = 1'b0;
          raise_n[c] = (served[c] < 2);
        end else if (raise_n[c]) begin
          gpu_if.mem_read_valid[c] = 1'b1;
          raise_n[c] = 1'b0;
        end
        if (gpu_if.mem_read_ready[c]) begin
          served[c]++;
          got++;
          drop_n[c] = 1'b1;
        end
      end
    end
    check("rr_grant_count", 32'(got), 32'd8);
    tick();
    gpu_if.mem_read_valid = '0;
    tick();

    // Hold bit: valid lingers one extra cycle after ready; no second grant may follow.
    expect_rsp(0, 1'b0, 8'h99);
    gpu_if.mem_read_address[0] = 8'h30;
    gpu_if.mem_read_valid[0]   = 1'b1;
    lat = 0;
    while (!gpu_if.mem_read_ready[0] && lat < 20) begin
      tick();
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd3);
    tick();
    tick();
    gpu_if.mem_read_valid[0] = 1'b0;
    n_rdy = 0; busy_cnt = 0;
    repeat (8) begin
      tick();
      if (|{gpu_if.mem_read_ready, gpu_if.mem_write_ready}) n_rdy++;
      if (busy) busy_cnt++;
    end
    check("hold_no_regrant", 32'(n_rdy), 32'd0);
    check("hold_idle_busy",  32'(busy_cnt), 32'd0);
    do_access("hold_rearm", 0, 1'b0, 8'h30, 8'h00, 8'h99);

    // Same channel read and write together with rr=0: read slot first.
    reset_and_check("rst_rw");
    expect_rsp(3, 1'b0, 8'h11);
    expect_rsp(3, 1'b1, 8'h00);
    gpu_if.mem_read_address[3]  = 8'h05;
    gpu_if.mem_write_address[3] = 8'h06;
    gpu_if.mem_write_data[3]    = 8'h77;
    gpu_if.mem_read_valid[3]    = 1'b1;
    gpu_if.mem_write_valid[3]   = 1'b1;
    cyc = 0; rd_at = 0; wr_at = 0; drop_rd = 1'b0; drop_wr = 1'b0;
    while ((rd_at == 0 || wr_at == 0) && cyc < 30) begin
      tick();
      cyc++;
      if (drop_rd) begin gpu_if.mem_read_valid[3] = 1'b0; drop_rd = 1'b0; end
      if (drop_wr) begin gpu_if.mem_write_valid[3] = 1'b0; drop_wr = 1'b0; end
      if (gpu_if.mem_read_ready[3])  begin rd_at = cyc; drop_rd = 1'b1; end
      if (gpu_if.mem_write_ready[3]) begin wr_at = cyc; drop_wr = 1'b1; end
    end
    tick();
    gpu_if.mem_read_valid[3]  = 1'b0;
    gpu_if.mem_write_valid[3] = 1'b0;
    tick();
    check("rw_read_cycle",  32'(rd_at), 32'd3);
    check("rw_write_cycle", 32'(wr_at), 32'd6);
    do_access("rw_readback", 0, 1'b0, 8'h06, 8'h00, 8'h77);

    // Reset during ACCESS: no ready for the abandoned access, then it is re-served.
    gpu_if.mem_read_address[2] = 8'h10;
    gpu_if.mem_read_valid[2]   = 1'b1;
    tick();
    check("mid_access_en", 32'({sram_en, sram_we, busy}), 32'b101);
    reset = 1'b1;
    tick();
    check_rst("rst_mid");
    reset = 1'b0;
    expect_rsp(2, 1'b0, 8'hA5);
    lat = 0;
    while (!gpu_if.mem_read_ready[2] && lat < 20) begin
      tick();
      lat++;
    end
    check("post_rst_latency", 32'(lat), 32'd3);
    tick();
    gpu_if.mem_read_valid[2] = 1'b0;
    tick();
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
